// File: rtl/exec_seq_pkg.sv
// Shared encodings for the multi-cycle execute sequencer: state, unit select, default latencies.
// Pure declarations; no logic, no latency.
// No flow control.
package exec_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_FADD = 2'b01;
    localparam logic [1:0] OP_FMUL = 2'b10;
    localparam logic [1:0] OP_FDIV = 2'b11;

    localparam int unsigned DEF_MUL_LAT  = 2;
    localparam int unsigned DEF_FADD_LAT = 3;
    localparam int unsigned DEF_FMUL_LAT = 4;
    localparam int unsigned DEF_FDIV_LAT = 8;

    // Counter preload value: RUN lasts lat cycles, ending on the cycle the count is zero.
    function automatic logic [3:0] lat_preload(input int unsigned lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/lat_counter.sv
// 4-bit loadable down-counter that saturates at zero.
// Load and decrement take effect on the next rising edge; zero is combinational.
// No flow control; load has priority over dec.
module lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/exec_sequencer.sv
// Sequences one long-latency unit operation: operand load, latency count, gated write-back.
// Accepted start -> LOAD next cycle -> LAT RUN cycles -> one WB cycle; issue interval LAT+3.
// Holds the main FSM with stall while busy; start while busy is dropped and flagged via collision.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
    parameter int unsigned FADD_LAT = DEF_FADD_LAT,
    parameter int unsigned FMUL_LAT = DEF_FMUL_LAT,
    parameter int unsigned FDIV_LAT = DEF_FDIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_kind,
    input  logic        cond_ok,
    input  logic        flag_s,
    input  logic        kill,
    input  logic [31:0] unit_result,
    input  logic [3:0]  unit_flags,
    output logic        opnd_le,
    output logic [1:0]  unit_sel,
    output logic        stall,
    output logic        done,
    output logic        reg_we,
    output logic        flag_we,
    output logic [31:0] result_q,
    output logic [3:0]  flags_q,
    output logic        collision
);

    state_t     state_q;
    state_t     state_d;
    logic       cond_q;
    logic       flag_s_q;
    logic       start_acc;
    logic       wb_enter;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic [3:0] lat_m1;

    assign start_acc = (state_q == ST_IDLE) && start && !kill;
    assign cnt_load  = (state_q == ST_LOAD);
    assign cnt_dec   = (state_q == ST_RUN);
    // Result is captured on the edge entering WB so it is stable during the write-back cycle.
    assign wb_enter  = (state_q == ST_RUN) && cnt_zero && !kill;
    assign collision = start && (state_q != ST_IDLE);

    always_comb begin
        lat_m1 = lat_preload(MUL_LAT);
        case (unit_sel)
            OP_MUL:  lat_m1 = lat_preload(MUL_LAT);
            OP_FADD: lat_m1 = lat_preload(FADD_LAT);
            OP_FMUL: lat_m1 = lat_preload(FMUL_LAT);
            OP_FDIV: lat_m1 = lat_preload(FDIV_LAT);
            default: lat_m1 = lat_preload(MUL_LAT);
        endcase
    end

    lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (lat_m1),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            unit_sel <= OP_MUL;
            cond_q   <= 1'b0;
            flag_s_q <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                unit_sel <= op_kind;
                cond_q   <= cond_ok;
                flag_s_q <= flag_s;
            end
            if (wb_enter) begin
                result_q <= unit_result;
                flags_q  <= unit_flags;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_le = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        reg_we  = 1'b0;
        flag_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                opnd_le = 1'b1;
                stall   = 1'b1;
                state_d = kill ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                stall = 1'b1;
                if (kill)          state_d = ST_IDLE;
                else if (cnt_zero) state_d = ST_WB;
            end
            ST_WB: begin
                done    = 1'b1;
                reg_we  = cond_q;
                flag_we = cond_q & flag_s_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle execute sequencer for the long-latency units behind the controller: the integer multiplier and the FPU adder, multiplier and divider. On a `start` from the main control FSM it latches operands, counts the selected unit's latency, and captures the unit's result and NZCV flags. It then issues one write-back cycle, with register and flag writes gated by the already-evaluated condition. While it is busy, the main FSM holds in its execute state via `stall`.

## Interface
Parameters:
- `MUL_LAT`, 2: integer multiply latency in cycles, range 1..15.
- `FADD_LAT`, 3: FP add/sub latency in cycles, range 1..15.
- `FMUL_LAT`, 4: FP multiply latency in cycles, range 1..15.
- `FDIV_LAT`, 8: FP divide latency in cycles, range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low; state is cleared on any edge where `reset`==0.
- `start`  in  1  request from main FSM; sampled only in IDLE.
- `op_kind`  in  2  00 MUL, 01 FADD, 10 FMUL, 11 FDIV; sampled with `start`.
- `cond_ok`  in  1  condition-pass from condlogic; sampled with `start`.
- `flag_s`  in  1  S-bit (update flags); sampled with `start`.
- `kill`  in  1  abort the in-flight operation.
- `unit_result`  in  32  result bus of the selected unit.
- `unit_flags`  in  4  NZCV from the selected unit.
- `opnd_le`  out  1  operand-register load enable.
- `unit_sel`  out  2  registered `op_kind` of the current operation.
- `stall`  out  1  hold the main FSM.
- `done`  out  1  one-cycle write-back pulse.
- `reg_we`  out  1  register-file write enable.
- `flag_we`  out  1  flag-register write enable.
- `result_q`  out  32  captured result.
- `flags_q`  out  4  captured NZCV.
- `collision`  out  1  one-cycle pulse: `start` seen while not IDLE.

## Operation
- Four states:
  - IDLE: waits for `start`.
  - LOAD: operand latch cycle.
  - RUN: counts the unit latency.
  - WB: write-back cycle.
- Transitions:
  - IDLE→LOAD on `start`&&!`kill`. `op_kind`, `cond_ok` and `flag_s` are registered in that cycle.
  - LOAD→RUN always. The counter loads the selected latency minus 1.
  - RUN decrements the counter each cycle. RUN→WB when the counter is 0.
  - WB→IDLE always.
- Outputs by state:
  - LOAD: `opnd_le`=1.
  - LOAD and RUN: `stall`=1.
  - WB: `done`=1 and `stall`=0. `result_q`/`flags_q` are loaded from `unit_result`/`unit_flags` on the WB clock edge.
  - WB: `reg_we`=registered `cond_ok`. `flag_we`=registered `cond_ok`&`flag_s`.
- `kill` in LOAD or RUN: next state IDLE. No `done`, no writes, `result_q`/`flags_q` unchanged.
- `kill` in WB is ignored; the write-back completes.
- `kill` together with `start` in IDLE: `kill` wins and `start` is dropped.
- `start` in LOAD, RUN or WB: ignored, and `collision`=1 for that cycle.
- `unit_sel` holds its registered value until the next accepted `start`.
- Reset values:
  - State IDLE, counter 0.
  - `result_q`=0, `flags_q`=0, `unit_sel`=0.
  - All 1-bit outputs 0.

## Timing
- `start` accepted at cycle 0 → LOAD at cycle 1 → RUN for cycles 2..LAT+1 → WB at cycle LAT+2 → IDLE at cycle LAT+3.
- `stall` is high in cycles 1..LAT+1. `done` is high only in cycle LAT+2.
- Back-to-back: a `start` in the first IDLE cycle after WB is accepted. Minimum issue interval is LAT+3 cycles.
- Control outputs (`opnd_le`, `stall`, `done`, `reg_we`, `flag_we`) are Moore outputs decoded from the registered state only.
- `collision` is combinational from `start` and state.
- `reset`==0 in any state forces IDLE on that edge. A partial operation produces no write.

## Structure
- Package `exec_seq_pkg` holds:
  - the 2-bit state encoding (IDLE=0, LOAD=1, RUN=2, WB=3);
  - `op_kind` constants `OP_MUL`, `OP_FADD`, `OP_FMUL`, `OP_FDIV`;
  - default latency constants.
- Sub-module `lat_counter`:
  - 4-bit loadable down-counter with `load`, `dec`, `zero` outputs;
  - same `clk`/`reset` convention as the parent.
- Latency select is a 4:1 mux on the registered `op_kind` inside `exec_sequencer`.

## Test plan
- MUL with `cond_ok`=1, `flag_s`=1, `unit_result`=0x0000_0030, `unit_flags`=4'b0000 → `done` at cycle 4, `reg_we`=`flag_we`=1, `result_q`=0x30, `stall` high cycles 1–3.
- FDIV with `cond_ok`=0 → `done` at cycle 10, `reg_we`=`flag_we`=0, `result_q` still captured.
- FMUL, `kill` asserted in cycle 3 (RUN) → IDLE at cycle 4, no `done`, `result_q` keeps its previous value; new `start` at cycle 4 is accepted.
- FADD, `start` re-asserted in cycles 1–5 → `collision` pulses in cycles 1–4. `start` in cycle 5 (WB) is not accepted and also pulses `collision`; the next operation begins only on a `start` in cycle 6.
- `reset`=0 in cycle 2 of MUL → all outputs 0 in cycle 3. `start`+`kill` together in IDLE → state stays IDLE.
- Back-to-back MUL, MUL with `start` on cycles 0 and 5 → `done` on cycles 4 and 9.
